wide_pio_commit: RTL and testbench

//  Parametrised Avalon-MM slave driving a wide parallel output (default 256 bits) from the HPS bus.
//  The HPS writes DATA_W-bit shadow words, then commits them atomically to out_data in one cycle.

---
 rtl/wide_pio_commit.sv | 155 +++++++++++++++
 tb/tb_wide_pio_commit.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/wide_pio_commit.sv
// wide_pio_commit
//   Avalon-MM slave that drives a wide parallel output from the HPS bus.
//   Software fills DATA_W-bit shadow words, then commits the whole shadow to
//   out_data in a single cycle so downstream logic never sees a half-updated
//   vector.
//
//   Address map (N = NUM_WORDS):
//     0 .. N-1     SHADOW[k]  R/W, byte enables honoured
//     N .. 2N-1    LIVE[k]    RO, word k of out_data
//     2N           CTRL       W: bit0 COMMIT, bit1 AUTO, bit2 CLEAR (reads 0)
//     2N+1         STATUS     RO: {out_hold, auto, pending}
//     2N+2         COUNT      RO: number of completed transfers (wraps)
//
//   Ports:
//     clk_clk, reset_reset_n      clock, asynchronous active-low reset
//     address/write/writedata/byteenable/read   Avalon-MM slave, no waitrequest
//     readdata/readdatavalid      read response, fixed latency of one cycle
//     out_hold                    downstream back-pressure on commits
//     out_data                    committed wide output
//     out_update                  one-cycle pulse in the cycle out_data changes
//
//   Handshake: a commit request is "valid" from the request edge until it is
//   transferred; out_hold=0 acts as "ready". The transfer happens on the first
//   edge where the request is pending and out_hold is low. Requests arriving
//   while one is already pending (including on the transfer edge) merge into it.
module wide_pio_commit #(
  parameter int                      DATA_W    = 32,
  parameter int                      OUT_W     = 256,
  parameter int                      ADDR_W    = 5,
  parameter logic [OUT_W-1:0]        RESET_VAL = '0
) (
  input  logic                  clk_clk,
  input  logic                  reset_reset_n,
  input  logic [ADDR_W-1:0]     address,
  input  logic                  write,
  input  logic [DATA_W-1:0]     writedata,
  input  logic [DATA_W/8-1:0]   byteenable,
  input  logic                  read,
  output logic [DATA_W-1:0]     readdata,
  output logic                  readdatavalid,
  input  logic                  out_hold,
  output logic [OUT_W-1:0]      out_data,
  output logic                  out_update
);

  localparam int NUM_WORDS = OUT_W / DATA_W;
  localparam int BE_W      = DATA_W / 8;

  localparam logic [ADDR_W-1:0] A_CTRL   = ADDR_W'(2 * NUM_WORDS);
  localparam logic [ADDR_W-1:0] A_STATUS = ADDR_W'(2 * NUM_WORDS + 1);
  localparam logic [ADDR_W-1:0] A_COUNT  = ADDR_W'(2 * NUM_WORDS + 2);
  localparam logic [ADDR_W-1:0] A_LAST   = ADDR_W'(NUM_WORDS - 1);

  typedef enum logic {
    S_IDLE    = 1'b0,
    S_PENDING = 1'b1
  } state_t;

  state_t             state, state_nx;
  logic [OUT_W-1:0]   shadow;
  logic               auto_mode;
  logic [31:0]        count;
  logic               pending;
  logic               ctrl_wr;
  logic               last_wr;
  logic               commit_req;
  logic               fire;
  logic [DATA_W-1:0]  rd_word;

  assign pending    = (state == S_PENDING);
  assign ctrl_wr    = write && (address == A_CTRL) && byteenable[0];
  assign last_wr    = write && (address == A_LAST);
  // auto_mode is the registered value, so the CTRL write that sets AUTO does
  // not itself trigger from a later-in-time shadow write on the same edge.
  assign commit_req = (ctrl_wr && writedata[0]) || (auto_mode && last_wr);

  // Commit FSM: next state and transfer strobe.
  always_comb begin
    state_nx = state;
    fire     = 1'b0;
    case (state)
      S_IDLE: begin
        if (commit_req) state_nx = S_PENDING;
      end
      S_PENDING: begin
        // A request on this same edge is absorbed by the transfer below.
        if (!out_hold) begin
          fire     = 1'b1;
          state_nx = S_IDLE;
        end
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      state      <= S_IDLE;
      out_data   <= RESET_VAL;
      out_update <= 1'b0;
      count      <= '0;
      auto_mode  <= 1'b0;
    end else begin
      state      <= state_nx;
      out_update <= fire;
      // shadow here is the value held before this edge, so writes landing on
      // the transfer edge are left for the next commit.
      if (fire) begin
        out_data <= shadow;
        count    <= count + 32'd1;
      end
      if (ctrl_wr) auto_mode <= writedata[1];
    end
  end

  // Shadow words: CLEAR wins (it shares the CTRL address, so it can never
  // coincide with a shadow write anyway).
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      shadow <= RESET_VAL;
    end else if (ctrl_wr && writedata[2]) begin
      shadow <= '0;
    end else begin
      for (int k = 0; k < NUM_WORDS; k++) begin
        for (int b = 0; b < BE_W; b++) begin
          if (write && (address == ADDR_W'(k)) && byteenable[b]) begin
            shadow[k*DATA_W + b*8 +: 8] <= writedata[b*8 +: 8];
          end
        end
      end
    end
  end

  // Read mux built from pre-edge values, so a same-cycle write is not visible.
  always_comb begin
    rd_word = '0;
    for (int k = 0; k < NUM_WORDS; k++) begin
      if (address == ADDR_W'(k))             rd_word = shadow[k*DATA_W +: DATA_W];
      if (address == ADDR_W'(NUM_WORDS + k)) rd_word = out_data[k*DATA_W +: DATA_W];
    end
    if (address == A_STATUS) rd_word = DATA_W'({out_hold, auto_mode, pending});
    if (address == A_COUNT)  rd_word = DATA_W'(count);
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      readdata      <= '0;
      readdatavalid <= 1'b0;
    end else begin
      readdatavalid <= read;
      readdata      <= read ? rd_word : '0;
    end
  end

endmodule

// File: tb/tb_wide_pio_commit.sv
// tb_wide_pio_commit
//   Directed bench for wide_pio_commit with default parameters
//   (DATA_W=32, OUT_W=256, ADDR_W=5, N=8). Expected committed vectors are built
//   from a bench-side copy of the shadow words and queued; a monitor pops one
//   per out_update pulse.
module tb_wide_pio_commit;

  localparam int A_LIVE0  = 8;
  localparam int A_CTRL   = 16;
  localparam int A_STATUS = 17;
  localparam int A_COUNT  = 18;

  logic         clk;
  logic         rst_n;
  logic [4:0]   address;
  logic         write;
  logic [31:0]  writedata;
  logic [3:0]   byteenable;
  logic         read;
  logic [31:0]  readdata;
  logic         readdatavalid;
  logic         out_hold;
  logic [255:0] out_data;
  logic         out_update;

  int           n_total;
  int           n_bad;
  int           n_upd;
  logic [31:0]  exp_sh [8];
  logic [255:0] exp_q[$];
  logic [31:0]  rd_val;

  wide_pio_commit dut (
    .clk_clk       (clk),
    .reset_reset_n (rst_n),
    .address       (address),
    .write         (write),
    .writedata     (writedata),
    .byteenable    (byteenable),
    .read          (read),
    .readdata      (readdata),
    .readdatavalid (readdatavalid),
    .out_hold      (out_hold),
    .out_data      (out_data),
    .out_update    (out_update)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- checking ----------------
  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [255:0] pack_sh();
    logic [255:0] v;
    for (int k = 0; k < 8; k++) v[k*32 +: 32] = exp_sh[k];
    return v;
  endfunction

  // Scoreboard: every out_update must match the oldest expected commit.
  always @(negedge clk) begin
    if (rst_n && out_update) begin
      n_upd++;
      chk("upd_expected", 256'(exp_q.size() != 0), 256'(1));
      if (exp_q.size() != 0) chk("upd_data", out_data, exp_q.pop_front());
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input int a, input logic [31:0] d, input logic [3:0] be);
    address    = 5'(a);
    writedata  = d;
    byteenable = be;
    write      = 1'b1;
    tick();
    write      = 1'b0;
    byteenable = 4'h0;
  endtask

  task automatic rd(input int a, output logic [31:0] d);
    address = 5'(a);
    read    = 1'b1;
    tick();
    read    = 1'b0;
    chk("rvalid", 256'(readdatavalid), 256'(1));
    d = readdata;
  endtask

  task automatic rd_chk(input string tag, input int a, input logic [31:0] exp);
    logic [31:0] v;
    rd(a, v);
    chk(tag, 256'(v), 256'(exp));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    n_total = 0; n_bad = 0; n_upd = 0;
    rst_n = 1'b0; address = '0; write = 1'b0; writedata = '0;
    byteenable = '0; read = 1'b0; out_hold = 1'b0;
    for (int k = 0; k < 8; k++) exp_sh[k] = '0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // 1: reset state
    chk("rst_out", out_data, '0);
    chk("rst_upd", 256'(out_update), 256'(0));
    chk("rst_rvalid", 256'(readdatavalid), 256'(0));
    rd_chk("rst_count", A_COUNT, 32'h0);
    rd_chk("rst_status", A_STATUS, 32'h0);
    for (int k = 0; k < 8; k++) rd_chk($sformatf("rst_live%0d", k), A_LIVE0 + k, 32'h0);

    // 2: fill shadow, nothing moves until COMMIT
    for (int k = 0; k < 8; k++) begin
      exp_sh[k] = 32'(32'h11111111 * k);
      wr(k, exp_sh[k], 4'hF);
    end
    tick();
    chk("s2_nocommit", out_data, '0);
    exp_q.push_back(pack_sh());
    wr(A_CTRL, 32'h1, 4'hF);
    chk("s2_lat_upd0", 256'(out_update), 256'(0));
    chk("s2_lat_data0", out_data, '0);
    tick();
    chk("s2_upd", 256'(out_update), 256'(1));
    chk("s2_word3", 256'(out_data[96 +: 32]), 256'(32'h33333333));
    tick();
    chk("s2_upd_off", 256'(out_update), 256'(0));
    chk("s2_nupd", 256'(n_upd), 256'(1));
    rd_chk("s2_count", A_COUNT, 32'd1);
    rd_chk("s2_shadow5", 5, 32'h55555555);
    rd_chk("s2_live7", A_LIVE0 + 7, 32'h77777777);
    // Read and write of the same word in one cycle returns the old value.
    address = 5'd1; writedata = 32'hCAFEF00D; byteenable = 4'hF;
    write = 1'b1; read = 1'b1;
    tick();
    write = 1'b0; read = 1'b0; byteenable = 4'h0;
    chk("s2_rw_old", 256'(readdata), 256'(32'h11111111));
    exp_sh[1] = 32'hCAFEF00D;
    rd_chk("s2_rw_new", 1, 32'hCAFEF00D);

    // 3: hold back-pressure, two requests merge into one transfer
    out_hold = 1'b1;
    wr(A_CTRL, 32'h1, 4'hF);
    wr(A_CTRL, 32'h1, 4'hF);
    rd_chk("s3_status_hold", A_STATUS, 32'h5);
    exp_sh[0] = 32'hA5A5A5A5;
    wr(0, exp_sh[0], 4'hF);
    repeat (3) tick();
    chk("s3_nupd_held", 256'(n_upd), 256'(1));
    chk("s3_live1_held", 256'(out_data[32 +: 32]), 256'(32'h11111111));
    exp_q.push_back(pack_sh());
    out_hold = 1'b0;
    repeat (3) tick();
    chk("s3_nupd", 256'(n_upd), 256'(2));
    rd_chk("s3_count", A_COUNT, 32'd2);
    rd_chk("s3_status", A_STATUS, 32'h0);
    // Second COMMIT lands on the transfer edge and is absorbed.
    exp_q.push_back(pack_sh());
    wr(A_CTRL, 32'h1, 4'hF);
    wr(A_CTRL, 32'h1, 4'hF);
    repeat (3) tick();
    chk("s3_coalesce_nupd", 256'(n_upd), 256'(3));
    rd_chk("s3_coalesce_count", A_COUNT, 32'd3);
    rd_chk("s3_coalesce_status", A_STATUS, 32'h0);

    // 4: AUTO mode, partial byte write to the last word
    wr(A_CTRL, 32'h2, 4'hF);
    rd_chk("s4_status_auto", A_STATUS, 32'h2);
    exp_sh[2] = 32'h12345678;
    wr(2, exp_sh[2], 4'hF);
    repeat (2) tick();
    chk("s4_no_auto_mid", 256'(n_upd), 256'(3));
    exp_sh[7] = 32'h7777BEEF;
    exp_q.push_back(pack_sh());
    wr(7, 32'hDEADBEEF, 4'b0011);
    tick();
    chk("s4_word7", 256'(out_data[224 +: 32]), 256'(32'h7777BEEF));
    tick();
    chk("s4_nupd", 256'(n_upd), 256'(4));
    rd_chk("s4_count", A_COUNT, 32'd4);

    // 5: CLEAR+COMMIT, then COUNT wrap
    for (int k = 0; k < 8; k++) exp_sh[k] = '0;
    exp_q.push_back(pack_sh());
    wr(A_CTRL, 32'h5, 4'hF);
    tick();
    chk("s5_clear_out", out_data, '0);
    tick();
    chk("s5_nupd", 256'(n_upd), 256'(5));
    rd_chk("s5_status", A_STATUS, 32'h0);
    rd_chk("s5_count", A_COUNT, 32'd5);
    force dut.count = 32'hFFFFFFFF;
    #1 release dut.count;
    rd_chk("s5_count_max", A_COUNT, 32'hFFFFFFFF);
    exp_sh[4] = 32'h00000044;
    wr(4, exp_sh[4], 4'hF);
    exp_q.push_back(pack_sh());
    wr(A_CTRL, 32'h1, 4'hF);
    repeat (2) tick();
    rd_chk("s5_count_wrap", A_COUNT, 32'h0);
    chk("s5_wrap_nupd", 256'(n_upd), 256'(6));

    // 6: reset while a held commit is pending
    exp_sh[3] = 32'hFFFF0000;
    wr(3, exp_sh[3], 4'hF);
    out_hold = 1'b1;
    wr(A_CTRL, 32'h1, 4'hF);
    rd_chk("s6_status_pend", A_STATUS, 32'h5);
    #2 rst_n = 1'b0;
    #1;
    chk("s6_rst_out", out_data, '0);
    chk("s6_rst_upd", 256'(out_update), 256'(0));
    chk("s6_rst_rvalid", 256'(readdatavalid), 256'(0));
    for (int k = 0; k < 8; k++) exp_sh[k] = '0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    out_hold = 1'b0;
    repeat (4) tick();
    chk("s6_nupd", 256'(n_upd), 256'(6));
    chk("s6_out", out_data, '0);
    rd_chk("s6_status", A_STATUS, 32'h0);
    rd_chk("s6_count", A_COUNT, 32'h0);
    rd_chk("s6_shadow3", 3, 32'h0);
    rd_chk("s6_live3", A_LIVE0 + 3, 32'h0);

    chk("final_q_empty", 256'(exp_q.size()), 256'(0));
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
